// File: rtl/la_cmd_pkg.sv
// ---------------------------------------------------------------------------
// la_cmd_pkg
// Shared types and constants for the logic-analyzer command stage:
//   op_t     - 2-bit command opcode
//   state_t  - cmd_dispatch FSM states
//   ACK/NAK  - default acknowledge bytes
//   field positions of the 16-bit host command and small field extractors
// ---------------------------------------------------------------------------
package la_cmd_pkg;

    typedef enum logic [1:0] {
        RD   = 2'b00,
        WR   = 2'b01,
        DUMP = 2'b10,
        ILL  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        WAIT_SENT,
        DUMP_RD,
        DUMP_TX,
        DUMP_WAIT
    } state_t;

    localparam logic [7:0] ACK_BYTE = 8'hA5;
    localparam logic [7:0] NAK_BYTE = 8'hEE;

    // Command layout: op = [15:14], addr = [13:8], data = [7:0], channel = [10:8]
    localparam int OP_LSB   = 14;
    localparam int ADDR_LSB = 8;
    localparam int ADDR_FW  = 6;
    localparam int DATA_LSB = 0;
    localparam int CH_LSB   = 8;
    localparam int MAX_CH   = 4;

    function automatic op_t cmd_op(input logic [15:0] c);
        return op_t'(c[OP_LSB +: 2]);
    endfunction

    function automatic logic [ADDR_FW-1:0] cmd_addr(input logic [15:0] c);
        return c[ADDR_LSB +: ADDR_FW];
    endfunction

    function automatic logic [2:0] cmd_ch(input logic [15:0] c);
        return c[CH_LSB +: 3];
    endfunction

    function automatic logic [7:0] cmd_data(input logic [15:0] c);
        return c[DATA_LSB +: 8];
    endfunction

    function automatic logic addr_in_range(input logic [ADDR_FW-1:0] a, input int n);
        return int'(a) < n;
    endfunction

endpackage

// File: rtl/cfg_regfile.sv
// ---------------------------------------------------------------------------
// cfg_regfile
// NUM_REGS x 8-bit configuration register array.
//   clk, rst_n   - clock, asynchronous active-low reset (all registers -> 0)
//   we           - write enable; out-of-range waddr is ignored
//   waddr, wdata - write port
//   raddr, rdata - combinational read port; out-of-range raddr reads 0
//   regs_flat    - every register, reg k on bits [8k+7:8k]
// ---------------------------------------------------------------------------
module cfg_regfile
    import la_cmd_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_FW-1:0]    waddr,
    input  logic [7:0]            wdata,
    input  logic [ADDR_FW-1:0]    raddr,
    output logic [7:0]            rdata,
    output logic [NUM_REGS*8-1:0] regs_flat
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [7:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && addr_in_range(waddr, NUM_REGS)) begin
            regs[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (addr_in_range(raddr, NUM_REGS)) begin
            rdata = regs[raddr[IDX_W-1:0]];
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_flat[8*k +: 8] = regs[k];
    end

endmodule

// File: rtl/cmd_dispatch.sv
// ---------------------------------------------------------------------------
// cmd_dispatch
// Decodes host commands from the UART command wrapper, executes register
// read/write or a capture-RAM dump, and returns response bytes.
//   clk, rst_n     - clock, asynchronous active-low reset
//   cmd_rdy, cmd   - command strobe (one cycle) and 16-bit command
//   clr_cmd_rdy    - pulses in the cycle a command is captured (IDLE only)
//   send_resp      - one-cycle pulse, resp is valid from that cycle on
//   resp           - registered response byte
//   resp_sent      - wrapper finished transmitting resp
//   regs_flat      - configuration registers, reg k on [8k+7:8k]
//   start_addr     - oldest sample address, sampled at dump entry
//   ram_addr, ch_sel, ram_rdata - capture RAM read port (1-cycle latency)
//
// Response handshake: send_resp is a one-cycle start strobe. From that cycle
// resp is held constant until the wrapper pulses resp_sent; no new
// send_resp is issued before that resp_sent, so at most one byte is ever in
// flight and send_resp is never high in two consecutive cycles.
// ---------------------------------------------------------------------------
module cmd_dispatch
    import la_cmd_pkg::*;
#(
    parameter int         NUM_REGS = 16,
    parameter int         DEPTH    = 384,
    parameter int         ADDR_W   = 9,
    parameter logic [7:0] ACK      = ACK_BYTE,
    parameter logic [7:0] NAK      = NAK_BYTE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_rdy,
    input  logic [15:0]           cmd,
    output logic                  clr_cmd_rdy,
    output logic                  send_resp,
    output logic [7:0]            resp,
    input  logic                  resp_sent,
    output logic [NUM_REGS*8-1:0] regs_flat,
    input  logic [ADDR_W-1:0]     start_addr,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [2:0]            ch_sel,
    input  logic [7:0]            ram_rdata
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t state, state_nx;

    logic [15:0]       cmd_q;
    logic [7:0]        resp_q;
    logic              send_q;
    logic [2:0]        ch_q;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] count;

    logic       capture;
    logic       in_sends;
    logic [7:0] in_resp;
    logic [7:0] rd_data;
    logic       q_wr_ok;
    logic       q_dump_ok;
    logic       wr_en;
    logic       dump_go;

    cfg_regfile #(.NUM_REGS(NUM_REGS)) u_regs (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (wr_en),
        .waddr     (cmd_addr(cmd_q)),
        .wdata     (cmd_data(cmd_q)),
        .raddr     (cmd_addr(cmd)),
        .rdata     (rd_data),
        .regs_flat (regs_flat)
    );

    assign capture = (state == IDLE) && cmd_rdy;

    // The response for register and error commands is decided from the live
    // command at capture, so resp and send_resp are already valid in EXEC.
    always_comb begin
        in_resp  = NAK;
        in_sends = 1'b1;
        case (cmd_op(cmd))
            RD:      if (addr_in_range(cmd_addr(cmd), NUM_REGS)) in_resp = rd_data;
            WR:      if (addr_in_range(cmd_addr(cmd), NUM_REGS)) in_resp = ACK;
            DUMP:    if (cmd_ch(cmd) <= 3'(MAX_CH)) in_sends = 1'b0;
            default: in_resp = NAK;
        endcase
    end

    assign q_wr_ok   = (cmd_op(cmd_q) == WR) && addr_in_range(cmd_addr(cmd_q), NUM_REGS);
    assign q_dump_ok = (cmd_op(cmd_q) == DUMP) && (cmd_ch(cmd_q) <= 3'(MAX_CH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        clr_cmd_rdy = 1'b0;
        wr_en       = 1'b0;
        dump_go     = 1'b0;
        case (state)
            IDLE: begin
                clr_cmd_rdy = cmd_rdy;
                if (cmd_rdy) state_nx = EXEC;
            end
            EXEC: begin
                wr_en   = q_wr_ok;
                dump_go = q_dump_ok;
                state_nx = q_dump_ok ? DUMP_RD : WAIT_SENT;
            end
            WAIT_SENT: if (resp_sent) state_nx = IDLE;
            DUMP_RD:   state_nx = DUMP_TX;
            DUMP_TX:   state_nx = DUMP_WAIT;
            DUMP_WAIT: if (resp_sent) state_nx = (count == LAST) ? IDLE : DUMP_RD;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= '0;
            resp_q <= '0;
            send_q <= 1'b0;
            ch_q   <= '0;
            ptr    <= '0;
            count  <= '0;
        end else begin
            send_q <= 1'b0;
            if (capture) begin
                cmd_q <= cmd;
                if (in_sends) begin
                    resp_q <= in_resp;
                    send_q <= 1'b1;
                end
            end
            if (dump_go) begin
                ch_q  <= cmd_ch(cmd_q);
                ptr   <= start_addr;
                count <= '0;
            end
            // ptr was presented in DUMP_RD, so ram_rdata now holds its sample
            if (state == DUMP_TX) begin
                resp_q <= ram_rdata;
                send_q <= 1'b1;
            end
            if ((state == DUMP_WAIT) && resp_sent && (count != LAST)) begin
                count <= count + 1'b1;
                ptr   <= (ptr == LAST) ? '0 : ptr + 1'b1;
            end
        end
    end

    assign send_resp = send_q;
    assign resp      = resp_q;
    assign ram_addr  = ptr;
    assign ch_sel    = ch_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
module tb_cmd_dispatch;
    import la_cmd_pkg::*;

    localparam int NUM_REGS = 16;
    localparam int DEPTH    = 384;
    localparam int ADDR_W   = 9;
    localparam int W        = 21; // {is_dump, ch[2:0], addr[8:0], byte[7:0]}

    // ---------------- clock / reset / DUT ----------------
    logic                  clk;
    logic                  rst_n;
    logic                  cmd_rdy;
    logic [15:0]           cmd;
    logic                  clr_cmd_rdy;
    logic                  send_resp;
    logic [7:0]            resp;
    logic                  resp_sent;
    logic [NUM_REGS*8-1:0] regs_flat;
    logic [ADDR_W-1:0]     start_addr;
    logic [ADDR_W-1:0]     ram_addr;
    logic [2:0]            ch_sel;
    logic [7:0]            ram_rdata;
    logic [ADDR_W-1:0]     ram_last_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cmd_dispatch #(.NUM_REGS(NUM_REGS), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .resp        (resp),
        .resp_sent   (resp_sent),
        .regs_flat   (regs_flat),
        .start_addr  (start_addr),
        .ram_addr    (ram_addr),
        .ch_sel      (ch_sel),
        .ram_rdata   (ram_rdata)
    );

    // Capture RAM: sample value = address low byte, one cycle read latency
    always @(posedge clk) begin
        ram_rdata     <= ram_addr[7:0];
        ram_last_addr <= ram_addr;
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0]      exp_q[$];
    logic [7:0]        exp_regs[NUM_REGS];
    logic [ADDR_W-1:0] dump_log[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  sent_cnt = 0;
    int  dump_seen = 0;
    int  dly_lo = 1;
    int  dly_hi = 4;
    bit  expect_accept = 0;
    bit  outstanding = 0;
    bit  prev_send = 0;
    logic [7:0] held;
    logic [7:0] last_resp;

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] model_resp(input logic [15:0] c);
        logic [1:0] op;
        logic [5:0] a;
        logic [2:0] ch;
        op = c[15:14];
        a  = c[13:8];
        ch = c[10:8];
        case (op)
            2'd0:    return (a < 6'd16) ? exp_regs[a[3:0]] : 8'hEE;
            2'd1:    return (a < 6'd16) ? 8'hA5 : 8'hEE;
            2'd2:    return (ch <= 3'd4) ? 8'h00 : 8'hEE;
            default: return 8'hEE;
        endcase
    endfunction

    function automatic logic [NUM_REGS*8-1:0] model_flat();
        logic [NUM_REGS*8-1:0] f;
        for (int k = 0; k < NUM_REGS; k++) f[8*k +: 8] = exp_regs[k];
        return f;
    endfunction

    // ---------------- wrapper model: acknowledges each byte after a delay ----
    initial begin
        int cd;
        cd = 0;
        resp_sent = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                resp_sent = 1'b0;
                cd = 0;
            end else begin
                resp_sent = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        resp_sent = 1'b1;
                        sent_cnt++;
                    end
                end else if (send_resp) begin
                    cd = $urandom_range(dly_hi, dly_lo);
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                outstanding = 0;
                prev_send   = 0;
            end else begin
                if (cmd_rdy || clr_cmd_rdy)
                    check(clr_cmd_rdy == (cmd_rdy && expect_accept), "clr_cmd_rdy",
                          clr_cmd_rdy, cmd_rdy && expect_accept);
                if (send_resp) begin
                    check(!prev_send && !outstanding, "send_spacing",
                          {prev_send, outstanding}, 0);
                    if (exp_q.size() == 0) begin
                        check(0, "unexpected_send", resp, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check(resp == e[7:0], "resp_byte", resp, e[7:0]);
                        if (e[20]) begin
                            check(ram_last_addr == e[16:8], "dump_addr", ram_last_addr, e[16:8]);
                            check(ch_sel == e[19:17], "dump_ch", ch_sel, e[19:17]);
                            dump_log.push_back(ram_last_addr);
                            dump_seen++;
                        end
                    end
                    outstanding = 1;
                    held        = resp;
                    last_resp   = resp;
                end else if (outstanding) begin
                    check(resp == held, "resp_hold", resp, held);
                end
                if (resp_sent) outstanding = 0;
                prev_send = send_resp;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [15:0] c);
        @(negedge clk);
        cmd = c;
        cmd_rdy = 1'b1;
        expect_accept = 1'b1;
        @(negedge clk);
        cmd_rdy = 1'b0;
        expect_accept = 1'b0;
        cmd = 16'($urandom);
    endtask

    task automatic wait_sent(input int tgt, input string name);
        int k;
        k = 0;
        while (sent_cnt < tgt && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check(sent_cnt >= tgt, name, sent_cnt, tgt);
    endtask

    task automatic do_cmd(input logic [15:0] c);
        int tgt;
        exp_q.push_back({13'b0, model_resp(c)});
        tgt = sent_cnt + 1;
        issue(c);
        wait_sent(tgt, "cmd_done");
        if (c[15:14] == 2'd1 && c[13:8] < 6'd16) exp_regs[c[11:8]] = c[7:0];
        check(regs_flat == model_flat(), "regs_flat", regs_flat, model_flat());
    endtask

    task automatic do_dump(input logic [8:0] st, input logic [2:0] ch,
                           input bit poke, input int stop_at);
        int  n, base_seen, base_sent, k;
        bit  done;
        logic [8:0] a;
        base_seen = dump_seen;
        base_sent = sent_cnt;
        if (ch <= 3'd4) begin
            n = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                a = 9'((int'(st) + i) % DEPTH);
                exp_q.push_back({1'b1, ch, a, a[7:0]});
            end
        end else begin
            n = 1;
            exp_q.push_back({13'b0, 8'hEE});
        end
        start_addr = st;
        issue({2'b10, 3'($urandom), ch, 8'($urandom)});
        @(negedge clk);
        start_addr = 9'($urandom);
        k = 0;
        done = 0;
        while (!done && k < 20000) begin
            @(negedge clk);
            cmd_rdy = 1'b0;
            k++;
            if (stop_at > 0) done = (dump_seen - base_seen) >= stop_at;
            else             done = (sent_cnt - base_sent) >= n;
            if (!done && poke && $urandom_range(0, 39) == 0) begin
                cmd = 16'($urandom);
                cmd_rdy = 1'b1;
            end
        end
        check(done, "dump_done", done, 1);
        if (stop_at == 0 && ch <= 3'd4)
            check(dump_seen - base_seen == DEPTH, "dump_bytes", dump_seen - base_seen, DEPTH);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int tgt;
        logic [NUM_REGS*8-1:0] snap;
        logic [15:0] c;
        logic [8:0]  first5[5];

        rst_n = 1'b0;
        cmd_rdy = 1'b0;
        cmd = '0;
        start_addr = '0;
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;

        // reset values
        repeat (3) @(negedge clk);
        #1;
        check(send_resp == 1'b0, "rst_send_resp", send_resp, 0);
        check(resp == 8'h00, "rst_resp", resp, 0);
        check(clr_cmd_rdy == 1'b0, "rst_clr", clr_cmd_rdy, 0);
        check(ram_addr == '0, "rst_ram_addr", ram_addr, 0);
        check(ch_sel == 3'd0, "rst_ch_sel", ch_sel, 0);
        check(regs_flat == '0, "rst_regs", regs_flat, 0);
        check(dut.state == IDLE, "rst_state", dut.state, IDLE);
        rst_n = 1'b1;

        // write reg 3 = 0x12, cycle-exact
        exp_q.push_back({13'b0, model_resp(16'h4312)});
        tgt = sent_cnt + 1;
        @(negedge clk);
        cmd = 16'h4312;
        cmd_rdy = 1'b1;
        expect_accept = 1'b1;
        #1 check(clr_cmd_rdy == 1'b1, "clr_same_cycle", clr_cmd_rdy, 1);
        @(negedge clk);
        cmd_rdy = 1'b0;
        expect_accept = 1'b0;
        #1 check({send_resp, resp} == {1'b1, 8'hA5}, "first_ack", {send_resp, resp}, {1'b1, 8'hA5});
        @(negedge clk);
        #1 check(regs_flat[31:24] == 8'h12, "reg3_n_plus_2", regs_flat[31:24], 8'h12);
        wait_sent(tgt, "first_done");
        exp_regs[3] = 8'h12;
        check(regs_flat == model_flat(), "regs_after_first", regs_flat, model_flat());

        // write then read back with a long acknowledge delay
        do_cmd(16'h435C);
        dly_lo = 100;
        dly_hi = 100;
        do_cmd(16'h0300);
        check(last_resp == 8'h5C, "read_reg3", last_resp, 8'h5C);
        dly_lo = 1;
        dly_hi = 4;

        // error responses
        snap = regs_flat;
        do_cmd(16'h5000);
        check(last_resp == 8'hEE, "nak_addr16", last_resp, 8'hEE);
        do_cmd(16'hC000);
        check(last_resp == 8'hEE, "nak_illegal", last_resp, 8'hEE);
        check(regs_flat == snap, "regs_unchanged", regs_flat, snap);

        // wrapping dump on channel 2 with stray commands while busy
        dump_log.delete();
        do_dump(9'd380, 3'd2, 1'b1, 0);
        first5 = '{9'd380, 9'd381, 9'd382, 9'd383, 9'd0};
        check(dump_log.size() == DEPTH, "dump_log_size", dump_log.size(), DEPTH);
        for (int i = 0; i < 5; i++)
            check(dump_log[i] == first5[i], "dump_first_addrs", dump_log[i], first5[i]);
        check(dump_log[DEPTH-1] == 9'd379, "dump_last_addr", dump_log[DEPTH-1], 9'd379);
        check(ch_sel == 3'd2, "dump_ch_sel", ch_sel, 2);
        repeat (3) @(negedge clk);
        #1 check(dut.state == IDLE, "dump_idle", dut.state, IDLE);

        // random register traffic
        repeat (80) begin
            c = 16'($urandom);
            c[13:8] = 6'($urandom_range(0, 19));
            if (c[15:14] == 2'd2) c[10:8] = 3'($urandom_range(5, 7));
            do_cmd(c);
        end

        // random dump, channel may be invalid
        do_dump(9'($urandom_range(0, DEPTH-1)), 3'($urandom_range(0, 7)), 1'b1, 0);

        // reset in the middle of a dump
        do_dump(9'($urandom_range(0, DEPTH-1)), 3'($urandom_range(0, 4)), 1'b0, 10);
        rst_n = 1'b0;
        #1;
        check(send_resp == 1'b0, "midrst_send", send_resp, 0);
        check(resp == 8'h00, "midrst_resp", resp, 0);
        check(dut.state == IDLE, "midrst_state", dut.state, IDLE);
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
        check(regs_flat == '0, "midrst_regs", regs_flat, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_cmd(16'h0000);
        check(last_resp == 8'h00, "read_reg0_after_rst", last_resp, 0);

        repeat (5) @(negedge clk);
        check(exp_q.size() == 0, "exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
